pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of consecutive memory wait cycles before a timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the negedge, matching the segment registers.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports id_rs1 and id_rs2, input, 4 bits each: source registers of the instruction in ID.
REQ-005 The block SHALL have ports id_use_rs1 and id_use_rs2, input, 1 bit each: qualify id_rs1 and id_rs2.
REQ-006 The block SHALL have port ex_memread, input, 1 bit: the instruction in EX is a load (MemToReg=1).
REQ-007 The block SHALL have port ex_rd, input, 4 bits: destination register of the instruction in EX.
REQ-008 The block SHALL have port ex_branch_taken, input, 1 bit: a taken branch or jump resolved in EX.
REQ-009 The block SHALL have port mem_req, input, 1 bit: the instruction in MEM accesses data memory.
REQ-010 The block SHALL have port dmem_ready, input, 1 bit: data memory completes the access this cycle.
REQ-011 The block SHALL have enable outputs pc_en, if_id_en, id_ex_en, ex_mem_en, 1 bit each.
REQ-012 The block SHALL have flush outputs if_id_flush and id_ex_flush, 1 bit each: the segment loads zeros.
REQ-013 The block SHALL have output mem_wb_bubble, 1 bit: the MEM/WB segment latches RegWrite=0 and MemToReg=0.
REQ-014 The block SHALL have status outputs dmem_timeout (1 bit, sticky), halted (1 bit) and stall_cnt (16 bits).

Function
REQ-015 The block SHALL define mw = mem_req & ~dmem_ready.
REQ-016 The block SHALL define lu = ex_memread & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); R0 SHALL NOT be a special case.
REQ-017 In state RUN, priority SHALL be mw > ex_branch_taken > lu, and only the highest active condition SHALL act in a cycle.
REQ-018 mw SHALL drive all four enables to 0 and mem_wb_bubble to 1, and flushes SHALL stay 0; this is a full freeze.
REQ-019 ex_branch_taken without mw SHALL drive if_id_flush=1 and id_ex_flush=1, with all enables at 1.
REQ-020 lu without mw or branch SHALL drive pc_en=0, if_id_en=0 and id_ex_flush=1, giving exactly one bubble; ex_mem_en SHALL stay 1.
REQ-021 With no condition active, all enables SHALL be 1, and flushes and bubble SHALL be 0.
REQ-022 All outputs except stall_cnt, dmem_timeout and halted SHALL be combinational from the inputs and the current state.
REQ-023 The FSM SHALL have the states RUN, WAIT and HALT.
REQ-024 The transition RUN->WAIT SHALL occur when mw is true, and the wait counter SHALL be loaded with 1.
REQ-025 In WAIT, mw SHALL increment the counter, and ~mw SHALL return the FSM to RUN with the counter cleared.
REQ-026 When mw is true in WAIT with counter==WAIT_MAX, the FSM SHALL move to HALT and set dmem_timeout.
REQ-027 In WAIT, outputs SHALL follow REQ-017 to REQ-021 using the current mw.
REQ-028 In HALT, all enables SHALL be 0, mem_wb_bubble SHALL be 1, halted SHALL be 1, and the FSM SHALL leave HALT only on reset.
REQ-029 stall_cnt SHALL increment on every negedge where pc_en=0, saturating at 16'hFFFF without wrapping.
REQ-030 When mw and ex_branch_taken are both true, the branch SHALL be held, not lost, because EX is frozen; it SHALL act in the first cycle after mw clears.

Reset
REQ-031 While rst=0, state SHALL be RUN, the wait counter 0, stall_cnt 0, dmem_timeout 0 and halted 0, asynchronously.
REQ-032 Reset asserted mid-WAIT or in HALT SHALL abort immediately; the first cycle after release SHALL behave as RUN.

Structure
REQ-033 Package pipe_pkg SHALL hold the state enum (RUN, WAIT, HALT), REG_W=4 and the WAIT_MAX default.
REQ-034 Load-use comparison (lu) SHALL be a combinational sub-module hazard_detect, instantiated once.

Verification
REQ-035 id_rs2=5, id_use_rs2=1, ex_memread=1, ex_rd=5 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt goes 0->1.
REQ-036 ex_branch_taken=1 together with lu -> if_id_flush=1, id_ex_flush=1, pc_en=1; stall_cnt unchanged.
REQ-037 mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 freeze cycles with mem_wb_bubble=1; FSM returns to RUN; stall_cnt=3.
REQ-038 mem_req=1, dmem_ready=0 for 20 cycles -> dmem_timeout=1 and halted=1 after 16 wait cycles; both remain set after dmem_ready=1.
REQ-039 rst pulsed low during WAIT at counter 7 -> all status bits 0 at once; no freeze after release if mw=0.
REQ-040 Forced stall for 70000 cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_pkg;

  localparam int REG_W        = 4;
  localparam int WAIT_MAX_DEF = 15;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: the instruction in ID reads a register that the load in EX is writing.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             lu
);

  // R0 is compared like any other register, so a load to R0 still stalls its consumer.
  assign lu = ex_memread & ((id_use_rs1 & (id_rs1 == ex_rd)) |
                            (id_use_rs2 & (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: freezes on data-memory wait, flushes on taken branch, bubbles on load-use,
// and halts after WAIT_MAX+1 consecutive memory wait cycles. State updates on the falling edge.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             dmem_timeout,
  output logic             halted,
  output logic [15:0]      stall_cnt
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             timeout_set;
  logic             mw;
  logic             lu;

  assign mw = mem_req & ~dmem_ready;

  hazard_detect u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_use_rs1 (id_use_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs2 (id_use_rs2),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .lu         (lu)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    timeout_set   = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;

    // A branch seen during a freeze is not lost: EX is frozen, so it re-presents once mw clears.
    if (state == HALT || mw) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    case (state)
      RUN: begin
        if (mw) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!mw) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d     = HALT;
          timeout_set = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      cnt          <= '0;
      dmem_timeout <= 1'b0;
      halted       <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (timeout_set) begin
        dmem_timeout <= 1'b1;
        halted       <= 1'b1;
      end
      if (!pc_en && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus randomized traffic against a
// cycle-level reference model built from the controller's rules.
module tb_pipe_ctrl;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, mem_req, dmem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble;
  logic        dmem_timeout, halted;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: run length of consecutive memory waits, sticky halt, stall count.
  int m_wait_run = 0;
  bit m_halted   = 0;
  int m_stall    = 0;

  pipe_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .dmem_timeout    (dmem_timeout),
    .halted          (halted),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected control vector {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, bubble}.
  function automatic logic [6:0] model_ctrl();
    bit mw, lu;
    mw = mem_req && !dmem_ready;
    lu = ex_memread && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (m_halted || mw)   return 7'b0000_001;
    if (ex_branch_taken)  return 7'b1111_110;
    if (lu)               return 7'b0011_010;
    return 7'b1111_000;
  endfunction

  function automatic logic [6:0] dut_ctrl();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble};
  endfunction

  task automatic set_in(input logic [3:0] rs1, input logic [3:0] rs2, input logic u1, input logic u2,
                        input logic mr, input logic [3:0] rd, input logic br, input logic mq,
                        input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_memread = mr; ex_rd = rd; ex_branch_taken = br; mem_req = mq; dmem_ready = rdy;
  endtask

  // One clock: outputs sampled at posedge, model advanced at negedge, status sampled just after.
  task automatic cycle(input string tag, input bit do_check);
    logic [6:0] exp_ctrl;
    @(posedge clk);
    exp_ctrl = model_ctrl();
    if (do_check) check({tag, "_ctrl"}, 32'(dut_ctrl()), 32'(exp_ctrl));
    @(negedge clk);
    if (!exp_ctrl[6] && m_stall < 65535) m_stall++;
    if (!m_halted) begin
      if (mem_req && !dmem_ready) begin
        m_wait_run++;
        if (m_wait_run > WAIT_MAX) m_halted = 1;
      end else begin
        m_wait_run = 0;
      end
    end
    #1;
    if (do_check) begin
      check({tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
      check({tag, "_timeout"}, 32'(dmem_timeout), 32'(m_halted));
      check({tag, "_halted"}, 32'(halted), 32'(m_halted));
    end
  endtask

  // Asynchronous reset pulse placed mid-cycle, with the status checked while reset is held.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    m_wait_run = 0; m_halted = 0; m_stall = 0;
    check({tag, "_rst_stall"}, 32'(stall_cnt), 32'd0);
    check({tag, "_rst_timeout"}, 32'(dmem_timeout), 32'd0);
    check({tag, "_rst_halted"}, 32'(halted), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic idle_in();
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    #1;
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    cycle("idle", 1'b1);

    // Load-use on rs2: exactly one bubble, stall_cnt 0 -> 1.
    set_in(4'd1, 4'd5, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    cycle("loaduse", 1'b1);
    check("loaduse_stall_is1", 32'(stall_cnt), 32'd1);
    idle_in();
    cycle("loaduse_after", 1'b1);

    // Load-use on R0 still stalls; unqualified match does not.
    set_in(4'd0, 4'd9, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    cycle("loaduse_r0", 1'b1);
    set_in(4'd5, 4'd5, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    cycle("no_use", 1'b1);

    // Branch together with load-use: branch wins, no stall.
    set_in(4'd5, 4'd2, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1);
    cycle("branch_lu", 1'b1);
    check("branch_lu_pc_en", 32'(pc_en), 32'd1);

    // Memory wait for 3 cycles with a branch held, then ready: branch acts after the freeze.
    pulse_reset("pre_mw3");
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle("mw3", 1'b1);
    check("mw3_stall_is3", 32'(stall_cnt), 32'd3);
    dmem_ready = 1'b1;
    cycle("mw3_branch", 1'b1);
    idle_in();
    cycle("mw3_run", 1'b1);
    check("mw3_stall_final", 32'(stall_cnt), 32'd3);

    // Timeout: 20 wait cycles, halt after the 16th, sticky once memory is ready.
    pulse_reset("pre_to");
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    repeat (15) cycle("to", 1'b1);
    check("to_not_yet", 32'(halted), 32'd0);
    cycle("to16", 1'b1);
    check("to_halted_16", 32'(halted), 32'd1);
    repeat (4) cycle("to_more", 1'b1);
    idle_in();
    repeat (3) cycle("to_sticky", 1'b1);
    check("to_sticky_timeout", 32'(dmem_timeout), 32'd1);

    // Reset in WAIT at counter 7, then normal run with no freeze.
    pulse_reset("pre_w7");
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    repeat (7) cycle("w7", 1'b1);
    pulse_reset("w7");
    idle_in();
    cycle("w7_after", 1'b1);
    check("w7_no_freeze", 32'(pc_en), 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) pulse_reset("rnd");
      set_in(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
             1'($urandom), 1'($urandom_range(0, 3) != 0));
      cycle("rnd", 1'b1);
    end

    // Long forced stall: saturate at 16'hFFFF.
    pulse_reset("pre_sat");
    set_in(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 70000; i++) cycle("sat", 1'b0);
    check("sat_model", 32'(stall_cnt), 32'(m_stall));
    check("sat_ffff", 32'(stall_cnt), 32'h0000_FFFF);
    cycle("sat_hold", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
